ddr_rd_fifo: RTL and testbench
==============================

Name: ddr_rd_fifo

Overview:
- Read-direction counterpart to the DDR write request buffer.
- Accepts read commands from the traffic generator and queues their addresses for the command dispatcher.
- Captures returned read data from the memory controller and delivers it to the traffic generator in order.
- Credit counting guarantees every issued read has a reserved return-buffer slot, so returned data is never dropped.

Parameters:
ADX_W, 27, read address width
DATA_W, 128, read data width
ADX_DEPTH, 16, address queue entries (power of 2)
DATA_DEPTH, 32, return data buffer entries (power of 2, >= ADX_DEPTH)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
rd_adx_in  input  ADX_W  read address from traffic generator
read_req  input  1  read request; ignored unless read_allowed
read_allowed  output  1  request may be accepted this cycle
reads_pending  output  1  registered: any read not yet consumed by traffic generator
rd_data_out  output  DATA_W  head of return buffer
rd_data_valid  output  1  return buffer non-empty
rd_data_ready  input  1  traffic generator consumes rd_data_out
get_rd_adx  input  1  dispatcher pops address queue
rd_adx_out  output  ADX_W  head of address queue (first-word fall-through)
has_rd_adx  output  1  address queue non-empty
rd_data_in  input  DATA_W  read data from memory controller
rd_data_in_valid  input  1  rd_data_in valid; no backpressure
rd_err  output  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset: asynchronous, active-low; all pointers and counters clear. While resetn=0: read_allowed=0, reads_pending=0, rd_data_valid=0, has_rd_adx=0, rd_err=0.
- Internal state is built from registers only; no vendor FIFO IP. Counters: adx_cnt (0..ADX_DEPTH), data_cnt (0..DATA_DEPTH), credits (0..DATA_DEPTH).
- credits = reads accepted minus beats consumed by the traffic generator. inflight = credits - adx_cnt - data_cnt.
- read_allowed is combinational from registered counters: (adx_cnt < ADX_DEPTH) && (credits < DATA_DEPTH). It is 1 after reset.
- Accept = read_req & read_allowed. On accept: rd_adx_in is written to the address queue; adx_cnt+1; credits+1.
- Address queue is first-word fall-through. has_rd_adx = (adx_cnt != 0). rd_adx_out is valid in the same cycle has_rd_adx is 1.
- Pop = get_rd_adx & has_rd_adx; get_rd_adx when empty is ignored. Accept and pop in the same cycle: adx_cnt unchanged, both take effect. Full plus pop: accept is still blocked that cycle, because read_allowed depends only on registered counts.
- On rd_data_in_valid: rd_data_in is written to the return buffer; data_cnt+1. Credits guarantee space.
- rd_data_valid = (data_cnt != 0). rd_data_out is valid in the same cycle.
- Consume = rd_data_ready & rd_data_valid: data_cnt-1; credits-1.
- Write into the empty return buffer: rd_data_valid rises on the next cycle (no bypass). Minimum latency from rd_data_in_valid to rd_data_valid is 1 cycle.
- Return write and consume in the same cycle: both take effect; data_cnt unchanged.
- Accept and consume in the same cycle: credits unchanged.
- reads_pending <= (credits != 0), registered. It is 1 cycle late relative to counter updates.
- Pointers wrap modulo depth. Counters never wrap: saturation is prevented by read_allowed.
- Protocol violations: rd_data_in_valid with inflight==0 (unsolicited data) or with data_cnt==DATA_DEPTH. The beat is dropped and no counter changes.

Optional Feature:
- Macro: DDR_RD_ERR_CHECK_EN.
- Defined: rd_err is set on the cycle after any protocol violation and holds until reset.
- Undefined: rd_err is tied to 0 and no violation detection logic is built. Violating beats are still dropped.

Test Plan:
- Reset then 3 reads at 0x10, 0x20, 0x30 -> has_rd_adx=1 the next cycle; rd_adx_out=0x10. Three pops yield 0x10, 0x20, 0x30; has_rd_adx=0.
- 16 back-to-back reads with no pops -> read_allowed=0 after the 16th accept. A 17th read_req is ignored. One pop -> read_allowed=1 the next cycle.
- 32 reads issued and popped, no data consumed -> credits=32, read_allowed=0. Return 32 beats 0..31 -> all buffered in order. Consume one -> read_allowed=1.
- Simultaneous accept, pop, return beat, and consume over 100 random cycles -> data order preserved; credits matches the scoreboard; no rd_err.
- Assert resetn=0 with 5 entries queued and 3 buffered -> outputs go to reset values immediately, asynchronously. After release: read_allowed=1, reads_pending=0.
- With DDR_RD_ERR_CHECK_EN defined, rd_data_in_valid with no inflight reads -> beat dropped, rd_err=1 the next cycle and sticky. With the macro undefined -> rd_err stays 0.

Source files
------------

// File: rtl/ddr_rd_fifo.sv
// ddr_rd_fifo: read address queue plus credit-reserved return data buffer.
// Define DDR_RD_ERR_CHECK_EN to build the sticky rd_err protocol checker.
module ddr_rd_fifo #(
  parameter int ADX_W      = 27,
  parameter int DATA_W     = 128,
  parameter int ADX_DEPTH  = 16,
  parameter int DATA_DEPTH = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADX_W-1:0]  rd_adx_in,
  input  logic              read_req,
  output logic              read_allowed,
  output logic              reads_pending,
  output logic [DATA_W-1:0] rd_data_out,
  output logic              rd_data_valid,
  input  logic              rd_data_ready,
  input  logic              get_rd_adx,
  output logic [ADX_W-1:0]  rd_adx_out,
  output logic              has_rd_adx,
  input  logic [DATA_W-1:0] rd_data_in,
  input  logic              rd_data_in_valid,
  output logic              rd_err
);
  localparam int AP = $clog2(ADX_DEPTH);
  localparam int DP = $clog2(DATA_DEPTH);
  localparam logic [AP:0] AFULL = (AP+1)'(ADX_DEPTH);
  localparam logic [DP:0] DFULL = (DP+1)'(DATA_DEPTH);
  logic [ADX_W-1:0]  adx_mem  [ADX_DEPTH];
  logic [DATA_W-1:0] data_mem [DATA_DEPTH];
  logic [AP-1:0] adx_wp, adx_rp;
  logic [DP-1:0] data_wp, data_rp;
  logic [AP:0]   adx_cnt;
  logic [DP:0]   data_cnt, credits, inflight;
  logic          accept, pop, push, consume, violation;
  // Gated by resetn so the request window is closed while reset is held.
  assign read_allowed  = resetn && (adx_cnt < AFULL) && (credits < DFULL);
  assign has_rd_adx    = adx_cnt != '0;
  assign rd_data_valid = data_cnt != '0;
  assign rd_adx_out    = adx_mem[adx_rp];
  assign rd_data_out   = data_mem[data_rp];
  assign accept        = read_req && read_allowed;
  assign pop           = get_rd_adx && has_rd_adx;
  assign consume       = rd_data_ready && rd_data_valid;
  assign inflight      = credits - (DP+1)'(adx_cnt) - data_cnt;
  // Unsolicited or overflowing beats are never written.
  assign violation     = rd_data_in_valid && (inflight == '0 || data_cnt == DFULL);
  assign push          = rd_data_in_valid && !violation;
  always_ff @(posedge clk) begin
    if (accept) adx_mem[adx_wp] <= rd_adx_in;
    if (push) data_mem[data_wp] <= rd_data_in;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      adx_wp        <= '0;
      adx_rp        <= '0;
      data_wp       <= '0;
      data_rp       <= '0;
      adx_cnt       <= '0;
      data_cnt      <= '0;
      credits       <= '0;
      reads_pending <= 1'b0;
    end else begin
      adx_wp        <= adx_wp + AP'(accept);
      adx_rp        <= adx_rp + AP'(pop);
      data_wp       <= data_wp + DP'(push);
      data_rp       <= data_rp + DP'(consume);
      adx_cnt       <= adx_cnt + (AP+1)'(accept) - (AP+1)'(pop);
      data_cnt      <= data_cnt + (DP+1)'(push) - (DP+1)'(consume);
      credits       <= credits + (DP+1)'(accept) - (DP+1)'(consume);
      reads_pending <= credits != '0;
    end
  end
`ifdef DDR_RD_ERR_CHECK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_err <= 1'b0;
    else if (violation) rd_err <= 1'b1;
  end
`else
  assign rd_err = 1'b0;
`endif
endmodule

// File: tb/tb_ddr_rd_fifo.sv
// tb_ddr_rd_fifo: directed plus random checks of ddr_rd_fifo against a queue-based model.
module tb_ddr_rd_fifo;
  localparam int AD = 16;
  localparam int DD = 32;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [26:0]  rd_adx_in = '0;
  logic         read_req = 1'b0;
  logic         read_allowed, reads_pending, rd_data_valid, has_rd_adx, rd_err;
  logic [127:0] rd_data_out, rd_data_in = '0;
  logic [26:0]  rd_adx_out;
  logic         rd_data_ready = 1'b0, get_rd_adx = 1'b0, rd_data_in_valid = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [26:0]  aq[$];
  logic [127:0] dq[$];
  int cred = 0;
  bit rp_m = 0, err_m = 0;
  ddr_rd_fifo dut (
    .clk(clk), .resetn(resetn), .rd_adx_in(rd_adx_in), .read_req(read_req),
    .read_allowed(read_allowed), .reads_pending(reads_pending), .rd_data_out(rd_data_out),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .get_rd_adx(get_rd_adx),
    .rd_adx_out(rd_adx_out), .has_rd_adx(has_rd_adx), .rd_data_in(rd_data_in),
    .rd_data_in_valid(rd_data_in_valid), .rd_err(rd_err)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit allowed_m();
    return resetn && aq.size() < AD && cred < DD;
  endfunction
  task automatic check_outputs();
    chk("read_allowed", read_allowed, allowed_m());
    chk("has_rd_adx", has_rd_adx, aq.size() != 0);
    chk("rd_data_valid", rd_data_valid, dq.size() != 0);
    chk("reads_pending", reads_pending, rp_m);
    chk("rd_err", rd_err, err_m);
    if (aq.size() != 0) chk("rd_adx_out", rd_adx_out, aq[0]);
    if (dq.size() != 0) chk("rd_data_out", rd_data_out, dq[0]);
  endtask
  // One clock: check state, advance model by the spec rules, return at the next negedge.
  task automatic cycle();
    bit acc, pop, cons, viol;
    int infl;
    check_outputs();
    acc  = read_req && allowed_m();
    pop  = get_rd_adx && aq.size() != 0;
    cons = rd_data_ready && dq.size() != 0;
    infl = cred - aq.size() - dq.size();
    viol = rd_data_in_valid && (infl == 0 || dq.size() == DD);
    @(posedge clk);
    rp_m = cred != 0;
`ifdef DDR_RD_ERR_CHECK_EN
    if (viol) err_m = 1;
`endif
    if (pop) void'(aq.pop_front());
    if (acc) aq.push_back(rd_adx_in);
    if (rd_data_in_valid && !viol) dq.push_back(rd_data_in);
    if (cons) void'(dq.pop_front());
    cred += int'(acc) - int'(cons);
    @(negedge clk);
  endtask
  task automatic idle();
    read_req = 0; get_rd_adx = 0; rd_data_in_valid = 0; rd_data_ready = 0;
  endtask
  task automatic do_reset();
    idle();
    resetn = 0;
    aq.delete(); dq.delete(); cred = 0; rp_m = 0; err_m = 0;
    @(negedge clk);
    check_outputs();
    resetn = 1;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    chk("reset_allowed", read_allowed, 1'b1);
    chk("reset_pending", reads_pending, 1'b0);
    // three reads, then three pops
    foreach (aq[i]) ;
    for (int i = 1; i <= 3; i++) begin
      read_req = 1; rd_adx_in = 27'(i * 16); cycle();
    end
    idle();
    chk("first_head", rd_adx_out, 27'h10);
    for (int i = 0; i < 4; i++) begin
      get_rd_adx = 1; cycle();
    end
    idle(); cycle();
    chk("queue_drained", has_rd_adx, 1'b0);
    // fill address queue, blocked 17th, pop with request still blocked
    do_reset();
    for (int i = 0; i < AD + 1; i++) begin
      read_req = 1; rd_adx_in = 27'($urandom); cycle();
    end
    chk("adx_full_block", read_allowed, 1'b0);
    get_rd_adx = 1; cycle();
    idle(); cycle();
    chk("adx_after_pop", read_allowed, 1'b1);
    // exhaust credits, return 32 beats, consume
    do_reset();
    for (int i = 0; i < 80 && !(cred == DD && aq.size() == 0); i++) begin
      read_req = 1; get_rd_adx = 1; rd_adx_in = 27'(i); cycle();
    end
    chk("credit_full", cred, DD);
    idle(); cycle();
    chk("credit_block", read_allowed, 1'b0);
    for (int i = 0; i < DD; i++) begin
      rd_data_in_valid = 1; rd_data_in = 128'(i); cycle();
    end
    idle();
    chk("buf_full_head", rd_data_out, 128'd0);
    rd_data_ready = 1; cycle();
    idle(); cycle();
    chk("credit_release", read_allowed, 1'b1);
    for (int i = 0; i < 40 && dq.size() != 0; i++) begin
      rd_data_ready = 1; cycle();
    end
    idle(); cycle();
    // random concurrent traffic, no protocol violations
    do_reset();
    for (int i = 0; i < 100; i++) begin
      read_req = 1'($urandom);
      rd_adx_in = 27'($urandom);
      get_rd_adx = 1'($urandom);
      rd_data_in_valid = (cred - aq.size() - dq.size() > 0) && ($urandom_range(3) != 0);
      rd_data_in = {$urandom, $urandom, $urandom, $urandom};
      rd_data_ready = 1'($urandom);
      cycle();
    end
    idle(); cycle();
    chk("random_no_err", rd_err, 1'b0);
    // asynchronous reset with 5 queued and 3 buffered
    do_reset();
    for (int i = 0; i < 8; i++) begin
      read_req = 1; rd_adx_in = 27'(100 + i); cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      get_rd_adx = 1; cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      rd_data_in_valid = 1; rd_data_in = 128'(200 + i); cycle();
    end
    idle(); cycle();
    chk("pre_rst_queued", aq.size(), 5);
    chk("pre_rst_valid", rd_data_valid, 1'b1);
    #2 resetn = 0;
    #1;
    chk("arst_allowed", read_allowed, 1'b0);
    chk("arst_pending", reads_pending, 1'b0);
    chk("arst_has_adx", has_rd_adx, 1'b0);
    chk("arst_valid", rd_data_valid, 1'b0);
    chk("arst_err", rd_err, 1'b0);
    do_reset();
    chk("post_rst_allowed", read_allowed, 1'b1);
    chk("post_rst_pending", reads_pending, 1'b0);
    // unsolicited beat is dropped
    rd_data_in_valid = 1; rd_data_in = 128'hdead; cycle();
    idle();
    for (int i = 0; i < 4; i++) cycle();
`ifdef DDR_RD_ERR_CHECK_EN
    chk("err_sticky", rd_err, 1'b1);
`else
    chk("err_tied", rd_err, 1'b0);
`endif
    chk("drop_valid", rd_data_valid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
